muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU controller for the PIPE MIPS EX stage. Time-shares the EX 32-bit add/sub unit
//  (33-bit result, op 0=add / 1=sub) to run radix-2 shift-add multiply and restoring divide, one adder pass per cycle.
//  Results go to HI/LO. o_busy stalls the pipeline on mfhi/mflo and on a new mult/div.
// PARAMETERS
//  WIDTH   32  operand width; iteration count = WIDTH
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_rst          in   1      synchronous, active-high reset
//  i_start        in   1      start request; sampled only in IDLE
//  i_op           in   1      0=multiply, 1=divide
//  i_signed       in   1      1=signed (MULT/DIV); see CONFIGURATION
//  i_flush        in   1      pipeline flush; aborts the op in flight
//  i_A            in   WIDTH  multiplicand / dividend
//  i_B            in   WIDTH  multiplier / divisor
//  o_add_a        out  WIDTH  shared adder operand A
//  o_add_b        out  WIDTH  shared adder operand B
//  o_add_op       out  1      shared adder op (0 add, 1 sub)
//  i_add_res      in   WIDTH+1 shared adder 33-bit result
//  o_busy         out  1      high from the cycle after accepted start until DONE inclusive
//  o_done         out  1      1-cycle pulse; o_hi/o_lo are valid and updated
//  o_div_by_zero  out  1      sticky until next accepted start; set at DONE for divide with i_B==0
//  o_hi, o_lo     out  WIDTH  HI/LO registers
// BEHAVIOUR
//  - Reset: state IDLE; o_busy=0, o_done=0, o_div_by_zero=0, o_hi=0, o_lo=0, o_add_*=0. Reset mid-op discards it.
//  - FSM: IDLE -> ITER (WIDTH cycles, counter 0..WIDTH-1) -> FIX (1) -> DONE (1) -> IDLE.
//  - Start accepted on a rising edge in IDLE with i_start=1. Operands are captured as magnitudes, and signs are latched.
//  - Latency: o_done is high on the 34th cycle after the accept edge (WIDTH=32). A new start is accepted the cycle after DONE.
//  - i_start outside IDLE is ignored (no queueing). i_flush in ITER/FIX/DONE goes to IDLE next cycle with o_hi/o_lo unchanged
//    and no o_done. i_flush beats i_start in the same IDLE cycle.
//  - Multiply ITER: o_add_a=P_hi, o_add_b=mcand, o_add_op=0. If the multiplier LSB is 1,
//    {carry,P_hi}=i_add_res; then {P_hi,P_lo} >>= 1 with carry in at the MSB.
//  - Divide ITER: R={R[30:0],Q[31]}, Q<<=1. o_add_a=shifted R, o_add_b=divisor, o_add_op=1.
//    If i_add_res[32]==1 (no borrow), R=i_add_res[31:0] and Q[0]=1; otherwise R is kept.
//  - FIX: signed multiply negates the 64-bit product if sA^sB. Signed divide negates Q if sA^sB and R if sA (MIPS rules).
//    The 64-bit product is the HI:LO concatenation. For divide, HI=remainder and LO=quotient.
//  - Divide by zero: no trap. The natural result is LO=32'hFFFF_FFFF (unsigned), HI=|dividend| with sign fix; o_div_by_zero=1.
//  - Signed -2^31 / -1 gives LO=32'h8000_0000, HI=0 (wrap, no flag).
//  - o_add_* are 0 outside ITER. The EX-stage mux gives the sequencer the adder only while o_busy=1.
// CONFIGURATION
//  MULDIV_SIGNED_EN defined: signed ops supported; abs capture and FIX negation are built.
//  Not defined: i_signed ignored, all ops unsigned, FIX is a 1-cycle no-op (latency unchanged), no negation logic.
// STRUCTURE
//  muldiv_pkg holds the FSM state encodings (IDLE/ITER/FIX/DONE), the op codes (OP_MUL=0, OP_DIV=1),
//  the adder op codes (ADD=0, SUB=1) and the default WIDTH.
//  Sub-module muldiv_sign_fix: combinational magnitude/negation of 2xWIDTH values, used at capture and in FIX.
// TESTING
//  1. MULTU A=32'hFFFF_FFFF B=32'hFFFF_FFFF -> done at cycle 34: HI=32'hFFFF_FFFE, LO=32'h0000_0001.
//  2. MULT A=-3 B=7 (signed EN) -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB; without the macro -> HI=6, LO=32'hFFFF_FFEB.
//  3. DIV A=-7 B=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). DIVU 100/7 -> LO=14, HI=2.
//  4. DIVU A=5 B=0 -> LO=32'hFFFF_FFFF, HI=5, o_div_by_zero=1; the next start clears the flag.
//  5. Start, i_flush at cycle 10 -> IDLE at cycle 11, no o_done, HI/LO keep prior values; i_start during busy is ignored.
//  6. i_rst at cycle 20 of a divide -> next cycle all outputs 0, IDLE; back-to-back starts yield o_done every 35 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: FSM states, op codes, adder op codes, default width.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic ADD_OP_ADD = 1'b0;
    localparam logic ADD_OP_SUB = 1'b1;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational two's-complement negation of a HI/LO pair: each half on its own, or the pair as one 2xWIDTH value.
// Only built when MULDIV_SIGNED_EN is defined; used for magnitude capture and for the final sign fix-up.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic             i_neg_hi,
    input  logic             i_neg_lo,
    input  logic             i_wide,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] wide_neg;

    always_comb begin
        wide_neg = ~{i_hi, i_lo} + (2*WIDTH)'(1);
        o_hi     = i_neg_hi ? (~i_hi + WIDTH'(1)) : i_hi;
        o_lo     = i_neg_lo ? (~i_lo + WIDTH'(1)) : i_lo;
        // In wide mode the borrow must ripple from LO into HI, so i_neg_lo governs the whole pair.
        if (i_wide && i_neg_lo) begin
            {o_hi, o_lo} = wide_neg;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer sharing the EX adder: one radix-2 step per cycle, done 34 cycles after accept (WIDTH=32).
// o_busy stalls the pipe from accept+1 through DONE; signed support only when MULDIV_SIGNED_EN is defined.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic             i_signed,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic [WIDTH-1:0] o_add_a,
    output logic [WIDTH-1:0] o_add_b,
    output logic             o_add_op,
    input  logic [WIDTH:0]   i_add_res,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [WIDTH-1:0] low_q, low_d;   // multiplier then product low half / dividend then quotient
    logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor magnitude
    logic             op_q, op_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             accept;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [WIDTH-1:0] div_shift;

    assign accept = (state_q == ST_IDLE) && i_start && !i_flush;

`ifdef MULDIV_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_hi_q, neg_hi_d;
    logic neg_lo_q, neg_lo_d;

    assign sign_a = i_signed & i_A[WIDTH-1];
    assign sign_b = i_signed & i_B[WIDTH-1];

    // MIPS rules: quotient sign is sA^sB, remainder follows the dividend.
    always_comb begin
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        if (accept) begin
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = (i_op == OP_MUL) ? (sign_a ^ sign_b) : sign_a;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
        end else begin
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
        end
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_capture (
        .i_hi     (i_A),
        .i_lo     (i_B),
        .i_neg_hi (sign_a),
        .i_neg_lo (sign_b),
        .i_wide   (1'b0),
        .o_hi     (mag_a),
        .o_lo     (mag_b)
    );

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .i_hi     (acc_q),
        .i_lo     (low_q),
        .i_neg_hi (neg_hi_q),
        .i_neg_lo (neg_lo_q),
        .i_wide   (op_q == OP_MUL),
        .o_hi     (fix_hi),
        .o_lo     (fix_lo)
    );
`else
    logic unused_signed;
    assign unused_signed = i_signed;
    assign mag_a  = i_A;
    assign mag_b  = i_B;
    assign fix_hi = acc_q;
    assign fix_lo = low_q;
`endif

    assign div_shift = {acc_q[WIDTH-2:0], low_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opb_d    = opb_q;
        op_d     = op_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        o_add_a  = '0;
        o_add_b  = '0;
        o_add_op = ADD_OP_ADD;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ITER;
                    cnt_d   = '0;
                    acc_d   = '0;
                    op_d    = i_op;
                    dbz_d   = 1'b0;
                    zero_d  = (i_op == OP_DIV) && (i_B == '0);
                    low_d   = (i_op == OP_MUL) ? mag_b : mag_a;
                    opb_d   = (i_op == OP_MUL) ? mag_a : mag_b;
                end
            end
            ST_ITER: begin
                if (op_q == OP_MUL) begin
                    o_add_a  = acc_q;
                    o_add_b  = opb_q;
                    o_add_op = ADD_OP_ADD;
                    if (low_q[0]) begin
                        {acc_d, low_d} = {i_add_res, low_q[WIDTH-1:1]};
                    end else begin
                        {acc_d, low_d} = {1'b0, acc_q, low_q[WIDTH-1:1]};
                    end
                end else begin
                    o_add_a  = div_shift;
                    o_add_b  = opb_q;
                    o_add_op = ADD_OP_SUB;
                    // Carry out of a - b means no borrow: the divisor fits.
                    if (i_add_res[WIDTH]) begin
                        acc_d = i_add_res[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift;
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                dbz_d   = zero_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_flush && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            dbz_d   = dbz_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opb_q   <= '0;
            op_q    <= OP_MUL;
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_DONE);
    assign o_div_by_zero = dbz_q;
    assign o_hi          = hi_q;
    assign o_lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: models the shared EX adder and checks results, latency, flush and reset.
module tb_muldiv_sequencer;

    logic        clk;
    logic        i_rst, i_start, i_op, i_signed, i_flush;
    logic [31:0] i_A, i_B;
    logic [31:0] add_a, add_b;
    logic        add_op;
    logic [32:0] add_res;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    int checks = 0;
    int fails  = 0;

    logic [31:0] c1_a, c1_b;
    logic        c1_op, c1_dbz, done_busy, ab_busy;
    int          lat;
    logic [31:0] exp_hi, exp_lo;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_op          (i_op),
        .i_signed      (i_signed),
        .i_flush       (i_flush),
        .i_A           (i_A),
        .i_B           (i_B),
        .o_add_a       (add_a),
        .o_add_b       (add_b),
        .o_add_op      (add_op),
        .i_add_res     (add_res),
        .o_busy        (busy),
        .o_done        (done),
        .o_div_by_zero (dbz),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    // EX-stage adder: 33-bit result, bit 32 is the carry out (no borrow on subtract).
    assign add_res = add_op ? ({1'b0, add_a} + {1'b0, ~add_b} + 33'd1)
                            : ({1'b0, add_a} + {1'b0, add_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 none, 1 flush at cycle abort_at, 2 reset at cycle abort_at, 3 stray start at cycle abort_at
    task automatic run_op(input logic op, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int abort_at, input int kind);
        for (int k = 0; k < 4 && busy; k++) step();
        lat = -1;
        ab_busy = 1'b1;
        done_busy = 1'b0;
        i_op = op; i_signed = sgn; i_A = a; i_B = b; i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 1) begin
                c1_a = add_a; c1_b = add_b; c1_op = add_op; c1_dbz = dbz;
            end
            if (done && lat < 0) begin
                lat = n;
                done_busy = busy;
            end
            if ((kind == 1 || kind == 2) && n == abort_at + 1) begin
                ab_busy = busy;
                i_flush = 1'b0;
                i_rst = 1'b0;
                break;
            end
            if ((kind == 0 || kind == 3) && lat > 0) break;
            if (n == abort_at) begin
                if (kind == 1) i_flush = 1'b1;
                if (kind == 2) i_rst = 1'b1;
                if (kind == 3) begin
                    i_start = 1'b1; i_op = ~op; i_A = 32'd9; i_B = 32'd3;
                end
            end
            if (kind == 3 && n == abort_at + 1) i_start = 1'b0;
            step();
        end
    endtask

    initial begin
        int first, second;
        i_rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_signed = 1'b0; i_flush = 1'b0;
        i_A = '0; i_B = '0;
        step(); step();
        i_rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_add", {add_op, add_a, add_b}, 0);

        // MULTU all-ones
        run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_latency", lat, 34);
        check("multu_busy_at_done", done_busy, 1);
        check("multu_c1_add", {c1_op, c1_a, c1_b}, {1'b0, 32'h0, 32'hFFFF_FFFF});
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);
        step();
        check("idle_after_done", {busy, done}, 0);

        // MULT -3 * 7
        run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 0, 0);
`ifdef MULDIV_SIGNED_EN
        check("mult_hi", hi, 32'hFFFF_FFFF);
`else
        check("mult_hi", hi, 32'd6);
`endif
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // DIV -7 / 2
        run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0);
`ifdef MULDIV_SIGNED_EN
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
`else
        check("div_lo", lo, 32'h7FFF_FFFC);
        check("div_hi", hi, 32'd1);
`endif

        // DIVU 100 / 7 with a stray start while busy
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 3, 3);
        check("divu_c1_add", {c1_op, c1_a, c1_b}, {1'b1, 32'h0, 32'd7});
        check("divu_latency", lat, 34);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        // DIVU 5 / 0
        run_op(1'b1, 1'b0, 32'd5, 32'd0, 0, 0);
        check("dbz_lo", lo, 32'hFFFF_FFFF);
        check("dbz_hi", hi, 32'd5);
        check("dbz_flag", dbz, 1);
        step();
        check("dbz_sticky", {busy, dbz}, 2'b01);

        // DIV -2^31 / -1
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("dbz_cleared_on_start", c1_dbz, 0);
        check("ovf_dbz", dbz, 0);
`ifdef MULDIV_SIGNED_EN
        exp_lo = 32'h8000_0000; exp_hi = 32'h0;
`else
        exp_lo = 32'h0; exp_hi = 32'h8000_0000;
`endif
        check("ovf_lo", lo, exp_lo);
        check("ovf_hi", hi, exp_hi);

        // Flush at cycle 10 of a multiply
        run_op(1'b0, 1'b0, 32'd3, 32'd5, 10, 1);
        check("flush_idle", ab_busy, 0);
        check("flush_no_done", lat, -1);
        check("flush_hilo_kept", {hi, lo}, {exp_hi, exp_lo});

        // Flush beats start in IDLE
        i_start = 1'b1; i_flush = 1'b1; i_op = 1'b0; i_A = 32'd2; i_B = 32'd2;
        step();
        i_start = 1'b0; i_flush = 1'b0;
        check("flush_beats_start", busy, 0);

        // Reset at cycle 20 of a divide
        run_op(1'b1, 1'b0, 32'd100, 32'd7, 20, 2);
        check("rst_mid_busy", ab_busy, 0);
        check("rst_mid_outputs", {done, dbz, hi, lo, add_op, add_a, add_b}, 0);

        // Back-to-back starts with i_start held high
        first = -1; second = -1;
        i_op = 1'b0; i_signed = 1'b0; i_A = 32'd3; i_B = 32'd5; i_start = 1'b1;
        for (int n = 0; n < 120; n++) begin
            step();
            if (done) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
            if (second >= 0) break;
        end
        i_start = 1'b0;
        check("b2b_seen", (first >= 0 && second >= 0), 1);
        check("b2b_period", second - first, 35);
        check("b2b_lo", lo, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
